rf_op_sequencer: RTL and testbench

RF_OP_SEQUENCER -- requirements
Module: rf_op_sequencer

---
 rtl/rf_seq_pkg.sv | 23 ++
 rtl/rf_seq_alu.sv | 61 ++++++
 rtl/rf_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_rf_op_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file operation sequencer:
// operation and state encodings plus the supported datapath widths.
package rf_seq_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MOV = 2'b10,
    OP_LHI = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB with signed overflow
// detection, MOV passes operand a, LHI places the immediate in the top byte.
module rf_seq_alu #(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        imm,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);
  import rf_seq_pkg::*;

  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;

  // Two operands of equal sign producing a result of the other sign overflowed.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] s);
    return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
  endfunction

  // x - y overflows when the operands differ in sign and the result sign flips from x.
  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] d);
    return (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
  endfunction

  assign sa   = $signed(a);
  assign sb   = $signed(b);
  assign sum  = sa + sb;
  assign diff = sa - sb;

  // Select the result and overflow flag for the requested operation.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result = sum;
        ovf    = add_ovf(sa, sb, sum);
      end
      OP_SUB: begin
        result = diff;
        ovf    = sub_ovf(sa, sb, diff);
      end
      OP_MOV: result = a;
      OP_LHI: result = {imm, {(DATA_W-8){1'b0}}};
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences one register-file operation at a time:
// accept command, read operands, execute, write back, then hand the
// result out on a valid/ready completion port.
module rf_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [7:0]        cmd_imm,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [ADDR_W-1:0] rf_addr3,
  output logic [DATA_W-1:0] rf_data3,
  output logic              rf_write,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [DATA_W-1:0] done_data,
  output logic              done_ovf,
  output logic [7:0]        op_count
);
  import rf_seq_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic [7:0]        imm_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] res_q;
  logic              ovf_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              accept;
  logic              done_hs;

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign done_hs = (state_q == ST_DONE) && done_ready;

  rf_seq_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .imm   (imm_q),
    .result(alu_res),
    .ovf   (alu_ovf)
  );

  // State register; a synchronous reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and all port outputs; every output is idle-zero outside its state.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    rf_addr1   = '0;
    rf_addr2   = '0;
    rf_addr3   = '0;
    rf_data3   = '0;
    rf_write   = 1'b0;
    done_valid = 1'b0;
    done_data  = '0;
    done_ovf   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_READ;
      end
      ST_READ: begin
        rf_addr1 = rs_q;
        rf_addr2 = rt_q;
        state_d  = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WRITE;
      ST_WRITE: begin
        rf_write = 1'b1;
        rf_addr3 = rd_q;
        rf_data3 = res_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done_valid = 1'b1;
        done_data  = res_q;
        done_ovf   = ovf_q;
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, operand capture in READ and result capture in EXEC.
  // Operands are read before the write-back, so rd aliasing rs/rt sees old values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        rs_q  <= cmd_rs;
        rt_q  <= cmd_rt;
        rd_q  <= cmd_rd;
        imm_q <= cmd_imm;
      end
      if (state_q == ST_READ) begin
        a_q <= rf_data1;
        b_q <= rf_data2;
      end
      if (state_q == ST_EXEC) begin
        res_q <= alu_res;
        ovf_q <= alu_ovf;
      end
    end
  end

  // Completed-command counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!reset_n)     cnt_q <= '0;
    else if (done_hs) cnt_q <= cnt_q + 8'd1;
  end

  assign op_count = cnt_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: pairs it with a 4x16 register file and checks
// directed scenarios plus a random command stream against a reference model.
module tb_rf_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op, cmd_rs, cmd_rt, cmd_rd;
  logic [7:0]  cmd_imm;
  logic [1:0]  rf_addr1, rf_addr2, rf_addr3;
  logic [15:0] rf_data1, rf_data2, rf_data3;
  logic        rf_write;
  logic        done_valid, done_ready;
  logic [15:0] done_data;
  logic        done_ovf;
  logic [7:0]  op_count;

  int checks = 0;
  int errors = 0;

  // register file paired with the block
  logic [15:0] rf [4];
  int unsigned write_pulses = 0;

  // reference model state
  logic [15:0] mrf [4];
  int          mcount = 0;

  always #5 clk = ~clk;

  rf_op_sequencer #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_rd    (cmd_rd),
    .cmd_imm   (cmd_imm),
    .rf_addr1  (rf_addr1),
    .rf_addr2  (rf_addr2),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .rf_addr3  (rf_addr3),
    .rf_data3  (rf_data3),
    .rf_write  (rf_write),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_data (done_data),
    .done_ovf  (done_ovf),
    .op_count  (op_count)
  );

  assign rf_data1 = rf[rf_addr1];
  assign rf_data2 = rf[rf_addr2];

  always @(posedge clk) begin
    if (rf_write === 1'b1) begin
      rf[rf_addr3] <= rf_data3;
      write_pulses <= write_pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of each op, computed with plain integer arithmetic.
  function automatic void model_exec(input logic [1:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic [7:0] imm,
                                     output logic [15:0] r, output logic ov);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    r  = 16'h0;
    ov = 1'b0;
    case (op)
      2'd0: begin s = sa + sb; r = s[15:0]; ov = (s > 32767) || (s < -32768); end
      2'd1: begin s = sa - sb; r = s[15:0]; ov = (s > 32767) || (s < -32768); end
      2'd2: r = a;
      default: r = imm * 16'd256;
    endcase
  endfunction

  // Issue one command, follow it to completion, hold DONE for 'hold' cycles.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [1:0] rd, input logic [7:0] imm,
                         input int hold, output logic [15:0] obs_data, output logic obs_ovf);
    logic [15:0] er;
    logic        eo;
    int          cyc;
    int          wr_cyc;
    bit          seen;
    @(negedge clk);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm;
    model_exec(op, mrf[rs], mrf[rt], imm, er, eo);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op  = 2'($urandom); cmd_rs = 2'($urandom); cmd_rt = 2'($urandom);
    cmd_rd  = 2'($urandom); cmd_imm = 8'($urandom);
    cyc = 0; wr_cyc = 0; seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (rf_write === 1'b1) begin
        if (wr_cyc == 0) wr_cyc = cyc;
        chk({tag, ".addr3"}, rf_addr3, rd);
        chk({tag, ".data3"}, rf_data3, er);
      end
      if (done_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, cyc, 4);
    chk({tag, ".write_cycle"}, wr_cyc, 3);
    chk({tag, ".done_data"}, done_data, er);
    chk({tag, ".done_ovf"}, done_ovf, eo);
    obs_data = done_data;
    obs_ovf  = done_ovf;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = (h == 0);
      cmd_rd = 2'($urandom); cmd_imm = 8'($urandom);
      done_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".hold_valid"}, done_valid, 1);
      chk({tag, ".hold_data"}, done_data, er);
      chk({tag, ".hold_ovf"}, done_ovf, eo);
      chk({tag, ".hold_cmd_ready"}, cmd_ready, 0);
      chk({tag, ".hold_write"}, rf_write, 0);
    end
    cmd_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    mrf[rd] = er;
    mcount  = (mcount + 1) % 256;
    chk({tag, ".op_count"}, op_count, mcount);
    chk({tag, ".idle_after"}, done_valid, 0);
  endtask

  logic [15:0] d;
  logic        o;
  int unsigned wp0;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; done_ready = 1'b0;
    cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_imm = '0;
    for (int i = 0; i < 4; i++) mrf[i] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.cmd_ready", cmd_ready, 1);
    chk("rst.rf_write", rf_write, 0);
    chk("rst.addr1", rf_addr1, 0);
    chk("rst.addr2", rf_addr2, 0);
    chk("rst.addr3", rf_addr3, 0);
    chk("rst.data3", rf_data3, 0);
    chk("rst.done_valid", done_valid, 0);
    chk("rst.done_data", done_data, 0);
    chk("rst.done_ovf", done_ovf, 0);
    chk("rst.op_count", op_count, 0);
    reset_n = 1'b1;

    // preload every register, then the LHI timing case
    for (int i = 0; i < 4; i++) run_cmd("preload", 2'd3, 2'($urandom), 2'($urandom), 2'(i), 8'($urandom), 0, d, o);
    run_cmd("lhi", 2'd3, 2'd0, 2'd0, 2'd1, 8'h12, 0, d, o);
    chk("lhi.const_data", d, 16'h1200);
    chk("lhi.const_ovf", o, 0);

    // signed overflow on ADD, no overflow on SUB
    run_cmd("ld_r1", 2'd3, 2'd0, 2'd0, 2'd1, 8'h70, 0, d, o);
    run_cmd("ld_r2", 2'd3, 2'd0, 2'd0, 2'd2, 8'h10, 0, d, o);
    run_cmd("add_ovf", 2'd0, 2'd1, 2'd2, 2'd3, 8'h00, 0, d, o);
    chk("add_ovf.const_data", d, 16'h8000);
    chk("add_ovf.const_ovf", o, 1);
    chk("add_ovf.r3", rf[3], 16'h8000);
    run_cmd("sub", 2'd1, 2'd2, 2'd1, 2'd0, 8'h00, 0, d, o);
    chk("sub.const_data", d, 16'hA000);
    chk("sub.const_ovf", o, 0);

    // rd aliasing rs/rt, and visibility of the previous write
    run_cmd("ld_r1b", 2'd3, 2'd0, 2'd0, 2'd1, 8'h12, 0, d, o);
    run_cmd("mov", 2'd2, 2'd1, 2'd3, 2'd1, 8'h00, 0, d, o);
    chk("mov.const_data", d, 16'h1200);
    run_cmd("add_self", 2'd0, 2'd1, 2'd1, 2'd1, 8'h00, 0, d, o);
    chk("add_self.const_data", d, 16'h2400);

    // completion back-pressure with an ignored command pulse
    run_cmd("hold", 2'd1, 2'd0, 2'd3, 2'd2, 8'h00, 3, d, o);
    for (int i = 0; i < 4; i++) chk("hold.rf", rf[i], mrf[i]);

    // reset during EXEC aborts the command, register file untouched
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_rs = 2'd0; cmd_rt = 2'd0; cmd_rd = 2'd2; cmd_imm = 8'h5A;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    wp0 = write_pulses;
    @(negedge clk);
    reset_n = 1'b1;
    mcount = 0;
    chk("abort.cmd_ready", cmd_ready, 1);
    chk("abort.op_count", op_count, 0);
    chk("abort.rf_write", rf_write, 0);
    chk("abort.done_valid", done_valid, 0);
    repeat (5) begin
      @(negedge clk);
      chk("abort.no_write", rf_write, 0);
    end
    chk("abort.pulses", write_pulses, wp0);
    for (int i = 0; i < 4; i++) chk("abort.rf_kept", rf[i], mrf[i]);

    // 256 random back-to-back commands: counter wraps, one write each
    wp0 = write_pulses;
    for (int n = 0; n < 256; n++)
      run_cmd("rand", 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 0, d, o);
    @(negedge clk);
    chk("wrap.op_count", op_count, 0);
    chk("wrap.pulses", write_pulses - wp0, 256);
    for (int i = 0; i < 4; i++) chk("wrap.rf", rf[i], mrf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
